// File: rtl/mac_32_scheduler_if.sv
// ---------------------------------------------------------------------------
// mac_32_scheduler_if
//   Bundles the requester-side operand streams and the result return channel
//   of mac_32_scheduler.
//
//   Signals:
//     req_valid  [NUM_REQ]      per-requester operand beat valid
//     req_last   [NUM_REQ]      final beat of the requester's vector
//     req_a/b    [16*NUM_REQ]   operands, requester i at [16i+15:16i]
//     req_ready  [NUM_REQ]      one-hot (or zero) beat accept
//     result_valid/ready        result handshake
//     result_data  [32]         accumulated sum of products
//     result_id    [IDW]        requester that produced result_data
//     result_beats [16]         beats accumulated (mod 2^16)
//     busy                      scheduler not idle
//
//   Modports:
//     master : requester engines + result consumer
//     slave  : the scheduler
// ---------------------------------------------------------------------------
interface mac_32_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  result_valid;
  logic                  result_ready;
  logic [31:0]           result_data;
  logic [IDW-1:0]        result_id;
  logic [15:0]           result_beats;
  logic                  busy;

  modport master (
    output req_valid, req_last, req_a, req_b, result_ready,
    input  req_ready, result_valid, result_data, result_id, result_beats, busy
  );

  modport slave (
    input  req_valid, req_last, req_a, req_b, result_ready,
    output req_ready, result_valid, result_data, result_id, result_beats, busy
  );
endinterface

// File: rtl/mac_32_scheduler.sv
// ---------------------------------------------------------------------------
// mac_32_scheduler
//   Round-robin scheduler sharing one 16x16 multiply / 32-bit accumulate
//   datapath among NUM_REQ requesters. A granted requester streams operand
//   beats until req_last; the dot product is returned tagged with its ID
//   and beat count, then the next requester (round-robin) is served.
//
//   Ports:
//     clock0 : single clock, rising edge
//     reset  : synchronous, active-high; returns everything to IDLE/zero
//     bus    : mac_32_scheduler_if.slave (operand streams + result channel)
//
//   Build option:
//     MAC_32_SCHED_SIGNED_EN : when defined, operands are two's-complement
//                              and the product is sign-extended before
//                              accumulation; otherwise unsigned.
//
//   Datapath stages:
//     p0 : operand mux from the granted requester (combinational)
//     p1 : product register
//     p2 : accumulator (wraps mod 2^32)
// ---------------------------------------------------------------------------
module mac_32_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clock0,
  input  logic               reset,
  mac_32_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  // 16x16 -> 32 multiply; only the operand sign handling is configurable.
  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
`ifdef MAC_32_SCHED_SIGNED_EN
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [31:0] sp;
    sa = a;
    sb = b;
    sp = sa * sb;
    return $unsigned(sp);
`else
    logic [31:0] ua;
    logic [31:0] ub;
    ua = {16'd0, a};
    ub = {16'd0, b};
    return ua * ub;
`endif
  endfunction

  // Accumulation deliberately wraps; no saturation.
  function automatic logic [31:0] wrap_add(input logic [31:0] x, input logic [31:0] y);
    return x + y;
  endfunction

  // Round-robin pick: first valid requester searching upward from last+1.
  // Returns {found, index}. Scanning from the far end lets the nearest
  // candidate overwrite any farther one.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                           input logic [IDW-1:0]     last);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx_w;
    int             idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx   = (int'(last) + k) % NUM_REQ;
      idx_w = IDW'(idx);
      if (vld[idx_w]) res = {1'b1, idx_w};
    end
    return res;
  endfunction

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW:0]   pick_w;
  logic           start;
  logic           beat_acc;

  logic [15:0]    a_p0;
  logic [15:0]    b_p0;
  logic [31:0]    prod_p1;
  logic           vld_p1;
  logic [31:0]    acc_p2;
  logic [15:0]    beats_q;

  assign pick_w = rr_pick(bus.req_valid, last_grant_q);

  // Control: next state, grant and beat acceptance.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    start         = 1'b0;
    beat_acc      = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_w[IDW]) begin
          grant_d = pick_w[IDW-1:0];
          start   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        bus.req_ready[grant_q] = 1'b1;
        if (bus.req_valid[grant_q]) begin
          beat_acc = 1'b1;
          if (bus.req_last[grant_q]) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Lets the final product reach the accumulator.
        state_d = RESULT;
      end
      RESULT: begin
        if (bus.result_ready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---- p0: operand select from the granted requester ----
  always_comb begin
    a_p0 = bus.req_a[16*int'(grant_q) +: 16];
    b_p0 = bus.req_b[16*int'(grant_q) +: 16];
  end

  // ---- p1: product register and beat counter ----
  always_ff @(posedge clock0) begin
    if (reset) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      beats_q <= '0;
    end else begin
      vld_p1 <= beat_acc;
      if (start) begin
        prod_p1 <= '0;
        beats_q <= '0;
      end else if (beat_acc) begin
        prod_p1 <= mul16(a_p0, b_p0);
        beats_q <= beats_q + 16'd1;
      end
    end
  end

  // ---- p2: accumulator ----
  always_ff @(posedge clock0) begin
    if (reset) begin
      acc_p2 <= '0;
    end else if (start) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= wrap_add(acc_p2, prod_p1);
    end
  end

  // Result fields come straight from registers, so they are stable for the
  // whole RESULT state (no product is in flight once DRAIN has passed).
  assign bus.result_valid = (state_q == RESULT);
  assign bus.result_data  = acc_p2;
  assign bus.result_id    = grant_q;
  assign bus.result_beats = beats_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mac_32_scheduler.sv
`timescale 1ns/1ps
module tb_mac_32_scheduler;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic clock0 = 1'b0;
  logic reset  = 1'b1;
  always #5 clock0 = ~clock0;

  mac_32_scheduler_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus();

  mac_32_scheduler #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clock0 (clock0),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct packed {logic [15:0] a; logic [15:0] b; logic last;} beat_t;
  typedef struct packed {logic [31:0] data; logic [15:0] beats;} res_t;

  beat_t bq [NUM_REQ][$];
  res_t  eq [NUM_REQ][$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = -100;
  int acc_cnt [NUM_REQ];
  int got_ids[$];
  int rv_rise[$];
  int exp_ids [5] = '{0, 1, 2, 3, 0};

  logic [NUM_REQ-1:0] hold = '0;
  bit rand_stall = 0, rand_ready = 0, rr_en = 1;
  logic prev_rv = 0, prev_hs = 0;
  logic [31:0] prev_data;
  logic [IDW-1:0] prev_id;
  logic [15:0] prev_beats;
  logic [31:0] last_data;
  logic [15:0] last_beats;
  int last_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product, straight from the arithmetic definition.
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef MAC_32_SCHED_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
`else
    longint p;
    p = longint'(a) * longint'(b);
    return p[31:0];
`endif
  endfunction

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < NUM_REQ; i++) if (bq[i].size() != 0 || eq[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic push_beat(input int r, input logic [15:0] a, input logic [15:0] b, input logic last);
    beat_t bt;
    bt.a = a; bt.b = b; bt.last = last;
    bq[r].push_back(bt);
  endtask

  task automatic push_exp(input int r, input logic [31:0] data, input logic [15:0] beats);
    res_t e;
    e.data = data; e.beats = beats;
    eq[r].push_back(e);
  endtask

  task automatic add_rand_vec(input int r);
    int n;
    logic [31:0] sum;
    logic [15:0] a, b;
    n = $urandom_range(1, 16);
    sum = 0;
    for (int k = 0; k < n; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      sum = sum + ref_prod(a, b);
      push_beat(r, a, b, k == n - 1);
    end
    push_exp(r, sum, 16'(n));
  endtask

  // One clock cycle: drive at the falling edge, observe, then advance.
  task automatic step();
    logic [NUM_REQ-1:0] v, l, acc;
    logic [16*NUM_REQ-1:0] av, bv;
    logic rdy;
    beat_t bt;
    res_t e;
    int id;
    v = '0; l = '0; av = '0; bv = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bq[i].size() > 0 && !hold[i] && (!rand_stall || $urandom_range(0, 7) != 0)) begin
        bt = bq[i][0];
        v[i] = 1'b1;
        l[i] = bt.last;
        av[16*i +: 16] = bt.a;
        bv[16*i +: 16] = bt.b;
      end
    end
    rdy = rr_en && (!rand_ready || $urandom_range(0, 3) != 0);
    bus.req_valid = v;
    bus.req_last = l;
    bus.req_a = av;
    bus.req_b = bv;
    bus.result_ready = rdy;
    #1;
    chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
    if (bus.result_valid && !prev_rv) begin
      rv_rise.push_back(cyc);
      chk("last_to_result_latency", 32'(cyc - last_acc_cyc), 2);
    end
    if (prev_rv && !prev_hs) begin
      chk("hold_valid", 32'(bus.result_valid), 1);
      chk("hold_data", bus.result_data, prev_data);
      chk("hold_id", 32'(bus.result_id), 32'(prev_id));
      chk("hold_beats", 32'(bus.result_beats), 32'(prev_beats));
    end
    if (bus.result_valid && rdy) begin
      id = int'(bus.result_id);
      got_ids.push_back(id);
      last_data = bus.result_data;
      last_beats = bus.result_beats;
      last_id = id;
      if (eq[id].size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = eq[id].pop_front();
        chk("result_data", bus.result_data, e.data);
        chk("result_beats", 32'(bus.result_beats), 32'(e.beats));
      end
    end
    acc = v & bus.req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        bt = bq[i].pop_front();
        acc_cnt[i]++;
        if (bt.last) last_acc_cyc = cyc;
      end
    end
    prev_rv = bus.result_valid;
    prev_hs = bus.result_valid & rdy;
    prev_data = bus.result_data;
    prev_id = bus.result_id;
    prev_beats = bus.result_beats;
    @(posedge clock0);
    @(negedge clock0);
    cyc++;
  endtask

  task automatic run_idle(input string tag, input int max);
    int n = 0;
    while ((pending() || bus.busy) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(pending() || bus.busy), 0);
  endtask

  task automatic apply_reset(input string tag);
    bus.req_valid = '0; bus.req_last = '0; bus.req_a = '0; bus.req_b = '0;
    bus.result_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock0);
    @(negedge clock0);
    cyc++;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_result_valid"}, 32'(bus.result_valid), 0);
    chk({tag, "_result_data"}, bus.result_data, 0);
    chk({tag, "_result_id"}, 32'(bus.result_id), 0);
    chk({tag, "_result_beats"}, 32'(bus.result_beats), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    reset = 1'b0;
    prev_rv = 0;
    prev_hs = 0;
    hold = '0;
  endtask

  initial begin
    int n, base, issued, r, c0;
    logic [31:0] d_snap;
    for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;

    // Power-on reset
    @(negedge clock0);
    apply_reset("por");

    // Requester 0: (3,4),(5,6) -> 42, ready one cycle after valid seen in IDLE
    chk("idle_ready", 32'(bus.req_ready), 0);
    push_beat(0, 16'd3, 16'd4, 1'b0);
    push_beat(0, 16'd5, 16'd6, 1'b1);
    push_exp(0, 32'd42, 16'd2);
    step();
    chk("grant_next_cycle", 32'(bus.req_ready), 32'b0001);
    run_idle("t2", 50);
    chk("t2_data", last_data, 32'd42);
    chk("t2_id", 32'(last_id), 0);
    chk("t2_beats", 32'(last_beats), 2);

    // All requesters valid, single-beat vectors -> round-robin order
    apply_reset("rst2");
    got_ids.delete();
    rv_rise.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      push_beat(i, 16'd1, 16'(i + 1), 1'b1);
      push_exp(i, 32'(i + 1), 16'd1);
    end
    push_beat(0, 16'd1, 16'd1, 1'b1);
    push_exp(0, 32'd1, 16'd1);
    c0 = cyc;
    run_idle("t3", 100);
    chk("t3_count", 32'(got_ids.size()), 5);
    for (int k = 0; k < 5 && k < got_ids.size(); k++) chk("t3_order", 32'(got_ids[k]), 32'(exp_ids[k]));
    if (rv_rise.size() > 0) chk("single_beat_latency", 32'(rv_rise[0] - c0), 3);
    else chk("single_beat_latency_seen", 0, 1);

    // Requester 2 drops valid for 3 cycles mid-vector
    for (int k = 0; k < 3; k++) push_beat(2, 16'hFFFF, 16'hFFFF, k == 2);
    push_exp(2, 32'(3) * ref_prod(16'hFFFF, 16'hFFFF), 16'd3);
    base = acc_cnt[2];
    n = 0;
    while (acc_cnt[2] < base + 1 && n < 20) begin step(); n++; end
    chk("t4_first_beat", 32'(acc_cnt[2] - base), 1);
    hold[2] = 1'b1;
    repeat (3) step();
    chk("t4_stalled", 32'(acc_cnt[2] - base), 1);
    chk("t4_busy", 32'(bus.busy), 1);
    hold[2] = 1'b0;
    run_idle("t4", 50);
    chk("t4_beats", 32'(last_beats), 3);
`ifdef MAC_32_SCHED_SIGNED_EN
    chk("t4_data", last_data, 32'd3);
`else
    chk("t4_data", last_data, 32'hFFFA_0003);
`endif

    // result_ready held low in RESULT
    rr_en = 0;
    push_beat(0, 16'd7, 16'd8, 1'b1);
    push_exp(0, 32'd56, 16'd1);
    n = 0;
    while (!bus.result_valid && n < 10) begin step(); n++; end
    chk("t5_result_valid", 32'(bus.result_valid), 1);
    push_beat(1, 16'd2, 16'd3, 1'b1);
    push_exp(1, 32'd6, 16'd1);
    d_snap = bus.result_data;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t5_no_grant", 32'(bus.req_ready), 0);
      chk("t5_data_stable", bus.result_data, d_snap);
    end
    chk("t5_data", d_snap, 32'd56);
    rr_en = 1;
    step();
    step();
    chk("t5_next_grant", 32'(bus.req_ready), 32'b0010);
    run_idle("t5", 50);

    // Reset mid-STREAM after 2 beats
    for (int k = 0; k < 4; k++) push_beat(3, 16'd1, 16'd1, k == 3);
    push_exp(3, 32'd4, 16'd4);
    base = acc_cnt[3];
    n = 0;
    while (acc_cnt[3] < base + 2 && n < 20) begin step(); n++; end
    chk("t6_two_beats", 32'(acc_cnt[3] - base), 2);
    apply_reset("t6_rst");
    bq[3].delete();
    eq[3].delete();
    push_beat(3, 16'd2, 16'd2, 1'b0);
    push_beat(3, 16'd2, 16'd2, 1'b1);
    push_exp(3, 32'd8, 16'd2);
    push_beat(0, 16'd1, 16'd5, 1'b1);
    push_exp(0, 32'd5, 16'd1);
    step();
    chk("t6_req0_first", 32'(bus.req_ready), 32'b0001);
    run_idle("t6", 50);

    // Randomized traffic against the reference model
    rand_stall = 1;
    rand_ready = 1;
    issued = 0;
    n = 0;
    while ((issued < 1000 || pending() || bus.busy) && n < 60000) begin
      if (issued < 1000) begin
        r = $urandom_range(0, NUM_REQ - 1);
        if (eq[r].size() < 3) begin
          add_rand_vec(r);
          issued++;
        end
      end
      step();
      n++;
    end
    chk("rand_drained", 32'(pending() || bus.busy), 0);
    chk("rand_issued", 32'(issued), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
